seq_mult16: RTL and testbench

SEQ_MULT16 -- requirements
Module: seq_mult16

---
 rtl/seq_mult16.sv | 183 ++++++++++++++++++
 tb/tb_seq_mult16.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_mult16.sv
// ---------------------------------------------------------------------------
// seq_mult16 : sequential 16x16 -> 32 unsigned shift-and-add multiplier.
//
// This file also contains cla16_ripple, the shared 16-bit adder. It is built
// from four 4-bit carry-lookahead groups with the carry rippling between them.
//
// seq_mult16 ports
//   clk   in   single clock; all state changes on its rising edge
//   rst   in   synchronous, active-high reset
//   start in   multiply request; honoured only while idle
//   a     in   WIDTH-bit unsigned multiplicand, sampled on the accepting edge
//   b     in   WIDTH-bit unsigned multiplier, sampled on the accepting edge
//   p     out  2*WIDTH-bit registered product; holds until the next completion
//   busy  out  high while the sixteen shift-add iterations run
//   done  out  one-cycle completion pulse
//
// cla16_ripple ports
//   a, b  in   16-bit addends
//   cin   in   carry in
//   s     out  16-bit sum
//   cout  out  carry out
// ---------------------------------------------------------------------------

module cla16_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    // One 4-bit lookahead group: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] pr;
        logic [4:0] c;
        g    = x & y;
        pr   = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (pr[0] & ci);
        c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & ci);
        c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0])
             | (pr[2] & pr[1] & pr[0] & ci);
        c[4] = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1])
             | (pr[3] & pr[2] & pr[1] & g[0])
             | (pr[3] & pr[2] & pr[1] & pr[0] & ci);
        return {c[4], pr ^ c[3:0]};
    endfunction

    logic [4:0] carry_s;
    logic [4:0] grp_s;

    // Chain the four lookahead groups, passing each group carry to the next.
    always_comb begin
        s          = 16'h0000;
        grp_s      = 5'b00000;
        carry_s    = 5'b00000;
        carry_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            grp_s          = cla4(a[4*i +: 4], b[4*i +: 4], carry_s[i]);
            s[4*i +: 4]    = grp_s[3:0];
            carry_s[i + 1] = grp_s[4];
        end
        cout = carry_s[4];
    end

endmodule

module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q,  state_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   p_q,      p_d;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 carry_s;

    // Partial product: the multiplicand only when the current multiplier LSB is set.
    assign addend_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};

    cla16_ripple u_add (
        .s    (sum_s),
        .cout (carry_s),
        .a    (acc_hi_q),
        .b    (addend_s),
        .cin  (1'b0)
    );

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_hi_d = {WIDTH{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Shift {carry, sum, mplier} right by one: the adder carry
                // becomes the new accumulator MSB, so it is never lost, and
                // the sum LSB drops into the vacated multiplier MSB.
                acc_hi_d = {carry_s, sum_s[WIDTH-1:1]};
                mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = {carry_s, sum_s, mplier_q[WIDTH-1:1]};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            p_q      <= {(2*WIDTH){1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    // Status flags decode straight from the state register, so they are
    // glitch-free and busy/done are mutually exclusive by construction.
    assign p    = p_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_mult16.sv
// ---------------------------------------------------------------------------
// tb_seq_mult16 : self-checking bench for seq_mult16.
// Reference model: the product is plain 32-bit arithmetic a*b, latency is a
// fixed 16 edges after acceptance, and p holds its previous value otherwise.
// ---------------------------------------------------------------------------

module tb_seq_mult16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] p_exp;

    always #5 clk = ~clk;

    seq_mult16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete multiply. hold keeps start high throughout; scramble
    // randomises a/b after acceptance; otherwise start toggles randomly
    // during RUN and DONE, where it must be ignored.
    task automatic mult(input logic [15:0] av, input logic [15:0] bv,
                        input bit hold, input bit scramble);
        logic [31:0] prod;
        int          edges;
        prod  = 32'(av) * 32'(bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();                                  // accepting edge E0
        chk("accept_busy", busy, 32'd1);
        chk("accept_done", done, 32'd0);
        if (!hold) start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            chk("run_busy", busy, 32'd1);
            chk("run_p_hold", p, p_exp);
            if (scramble) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            if (!hold) start = 1'($urandom);
            step();
            edges++;
        end
        chk("latency", edges, 32'd16);
        p_exp = prod;
        chk("product", p, p_exp);
        chk("done_not_busy", busy, 32'd0);
        if (!hold) start = 1'($urandom);     // start during DONE is ignored
        step();                                  // E17
        chk("done_single", done, 32'd0);
        chk("idle_busy", busy, 32'd0);
        chk("p_after", p, p_exp);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        p_exp = 32'h0000_0000;

        // Reset defaults on the first edge with rst high
        step();
        chk("reset_p", p, 32'h0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_done", done, 32'd0);
        step();
        rst = 1'b0;

        // Max operands, accepted on the first edge after reset release
        mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        chk("max_const", p, 32'hFFFE_0001);

        // Zero operands
        mult(16'h0000, 16'hBEEF, 1'b0, 1'b0);
        chk("zero_a", p, 32'h0);
        mult(16'hBEEF, 16'h0000, 1'b0, 1'b0);
        chk("zero_b", p, 32'h0);

        // Mixed operands with a/b randomised after acceptance
        mult(16'd1234, 16'd5678, 1'b0, 1'b1);
        chk("mixed_const", p, 32'h006A_E9BC);

        // Random operands
        for (int i = 0; i < 10; i++) begin
            mult(16'($urandom), 16'($urandom), 1'b0, (i % 2) == 1);
        end

        // start held high: back-to-back products every 18 edges
        for (int k = 0; k < 3; k++) begin
            mult(16'($urandom), 16'($urandom), 1'b1, 1'b0);
        end
        start = 1'b0;
        step();

        // Make sure p is non-zero so the reset clear is observable
        mult(16'hA5A5, 16'h1234, 1'b0, 1'b0);

        // Reset mid-run at E8
        a     = 16'h7777;
        b     = 16'h3333;
        start = 1'b1;
        step();                                  // E0
        start = 1'b0;
        repeat (7) step();                       // E1..E7
        chk("midrun_busy", busy, 32'd1);
        rst = 1'b1;
        step();                                  // E8 with reset
        p_exp = 32'h0;
        chk("abort_p", p, 32'h0);
        chk("abort_busy", busy, 32'd0);
        chk("abort_done", done, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("no_done_after_abort", done, 32'd0);
            chk("no_busy_after_abort", busy, 32'd0);
            step();
        end
        mult(16'd3, 16'd5, 1'b0, 1'b0);
        chk("post_abort_3x5", p, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
